// File: rtl/board_io_pkg.sv
// Shared defaults and colour-depth helper for the board I/O adapter.
// The expansion helper works on a fixed MAX_BPC-wide container; callers slice the result.
package board_io_pkg;

    localparam int DIV_DEF        = 4;
    localparam int N_BTN_DEF      = 3;
    localparam int DEB_CYCLES_DEF = 1000000;
    localparam int IN_BPC_DEF     = 1;
    localparam int OUT_BPC_DEF    = 4;
    localparam bit SYNC_IDLE_DEF  = 1'b1;
    localparam int MAX_BPC        = 16;
    localparam int IDXW           = $clog2(MAX_BPC);

    // MSB-first replication: output bit i (from the top) takes input bit (i mod in_bpc).
    function automatic logic [MAX_BPC-1:0] expand_bpc(input logic [MAX_BPC-1:0] in_v,
                                                      input int in_bpc,
                                                      input int out_bpc);
        logic [MAX_BPC-1:0] res;
        logic [IDXW-1:0]    oi;
        logic [IDXW-1:0]    ii;
        res = '0;
        for (int i = 0; i < MAX_BPC; i++) begin
            if (i < out_bpc && in_bpc > 0) begin
                oi      = IDXW'(out_bpc - 1 - i);
                ii      = IDXW'(in_bpc - 1 - (i % in_bpc));
                res[oi] = in_v[ii];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/board_io_adapter_btn_debounce.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level and press flag.
// rise_now is combinational so the stretch register in the top sets on the same edge as the level.
module btn_debounce
    import board_io_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_now
);

    localparam int            CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          s;

    assign s = sync_q[1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            level_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level    = level_q;
    assign rise_now = level_d & ~level_q;

endmodule

// File: rtl/board_io_adapter.sv
// Board-side adapter: pixel divider, debounced/stretched buttons, and a pix_ce-aligned
// video register that widens core colour to the DAC width.
module board_io_adapter
    import board_io_pkg::*;
#(
    parameter int DIV        = DIV_DEF,
    parameter int N_BTN      = N_BTN_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int IN_BPC     = IN_BPC_DEF,
    parameter int OUT_BPC    = OUT_BPC_DEF,
    parameter bit SYNC_IDLE  = SYNC_IDLE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_BTN-1:0]   btn_raw,
    output logic               pix_ce,
    output logic               pix_clk,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   btn_rise,
    input  logic [IN_BPC-1:0]  core_r,
    input  logic [IN_BPC-1:0]  core_g,
    input  logic [IN_BPC-1:0]  core_b,
    input  logic               core_hs,
    input  logic               core_vs,
    output logic [OUT_BPC-1:0] vga_r,
    output logic [OUT_BPC-1:0] vga_g,
    output logic [OUT_BPC-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs
);

    if (DIV < 2 || (DIV % 2) != 0 || DEB_CYCLES < 1 || IN_BPC < 1 ||
        OUT_BPC < IN_BPC || OUT_BPC > MAX_BPC || N_BTN < 1) begin : g_bad_params
        $error("board_io_adapter: illegal parameter combination");
    end

    // Pixel divider
    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pix_clk_q;

    assign cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    assign pix_ce = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pix_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pix_clk_q <= (cnt_d >= HALF);
        end
    end

    assign pix_clk = pix_clk_q;

    // Buttons
    logic [N_BTN-1:0] rise_now;
    logic [N_BTN-1:0] rise_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (btn_raw[i]),
            .level   (btn_level[i]),
            .rise_now(rise_now[i])
        );
    end

    // A press pulse survives until a pix_ce edge that did not also set it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rise_q <= '0;
        else        rise_q <= (rise_q & ~{N_BTN{pix_ce}}) | rise_now;
    end

    assign btn_rise = rise_q;

    // Video register
    logic [MAX_BPC-1:0] r_x, g_x, b_x;
    logic [OUT_BPC-1:0] vga_r_q, vga_g_q, vga_b_q;
    logic               vga_hs_q, vga_vs_q;

    assign r_x = expand_bpc(MAX_BPC'(core_r), IN_BPC, OUT_BPC);
    assign g_x = expand_bpc(MAX_BPC'(core_g), IN_BPC, OUT_BPC);
    assign b_x = expand_bpc(MAX_BPC'(core_b), IN_BPC, OUT_BPC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r_q  <= '0;
            vga_g_q  <= '0;
            vga_b_q  <= '0;
            vga_hs_q <= SYNC_IDLE;
            vga_vs_q <= SYNC_IDLE;
        end else if (pix_ce) begin
            vga_r_q  <= r_x[OUT_BPC-1:0];
            vga_g_q  <= g_x[OUT_BPC-1:0];
            vga_b_q  <= b_x[OUT_BPC-1:0];
            vga_hs_q <= core_hs;
            vga_vs_q <= core_vs;
        end
    end

    assign vga_r  = vga_r_q;
    assign vga_g  = vga_g_q;
    assign vga_b  = vga_b_q;
    assign vga_hs = vga_hs_q;
    assign vga_vs = vga_vs_q;

endmodule

// File: tb/tb_board_io_adapter.sv
// Bench for board_io_adapter: two instances (1->4 and 2->4 colour), a cycle-count/history
// reference model checked every cycle, a vector table for the video path and directed corners.
module tb_board_io_adapter;

    localparam int DIV   = 4;
    localparam int N_BTN = 3;
    localparam int DEB   = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [N_BTN-1:0] btn_raw = '0;
    logic             core_r1 = 0, core_g1 = 0, core_b1 = 0, core_hs = 0, core_vs = 0;
    logic [1:0]       core_r2 = '0, core_g2 = '0, core_b2 = '0;

    logic             pix_ce, pix_clk, pix_ce2, pix_clk2;
    logic [N_BTN-1:0] btn_level, btn_rise, btn_level2, btn_rise2;
    logic [3:0]       vga_r1, vga_g1, vga_b1, vga_r2, vga_g2, vga_b2;
    logic             vga_hs1, vga_vs1, vga_hs2, vga_vs2;

    board_io_adapter #(.DIV(DIV), .N_BTN(N_BTN), .DEB_CYCLES(DEB), .IN_BPC(1), .OUT_BPC(4),
                       .SYNC_IDLE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .pix_ce(pix_ce), .pix_clk(pix_clk),
        .btn_level(btn_level), .btn_rise(btn_rise),
        .core_r(core_r1), .core_g(core_g1), .core_b(core_b1), .core_hs(core_hs), .core_vs(core_vs),
        .vga_r(vga_r1), .vga_g(vga_g1), .vga_b(vga_b1), .vga_hs(vga_hs1), .vga_vs(vga_vs1));

    board_io_adapter #(.DIV(DIV), .N_BTN(N_BTN), .DEB_CYCLES(DEB), .IN_BPC(2), .OUT_BPC(4),
                       .SYNC_IDLE(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .pix_ce(pix_ce2), .pix_clk(pix_clk2),
        .btn_level(btn_level2), .btn_rise(btn_rise2),
        .core_r(core_r2), .core_g(core_g2), .core_b(core_b2), .core_hs(core_hs), .core_vs(core_vs),
        .vga_r(vga_r2), .vga_g(vga_g2), .vga_b(vga_b2), .vga_hs(vga_hs2), .vga_vs(vga_vs2));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected colour expansion by plain arithmetic.
    function automatic logic [3:0] x1(input logic a);
        return a ? 4'hF : 4'h0;
    endfunction
    function automatic logic [3:0] x2(input logic [1:0] v);
        return 4'(v * 5);
    endfunction

    // Reference model: edges counted since reset release; button levels from a window of
    // synchronised samples (a level flips once DEB consecutive samples all disagree with it).
    int               m_cyc;
    logic [N_BTN-1:0] m_hist[$];
    logic [N_BTN-1:0] m_level, m_rise;
    logic [13:0]      m_vid1, m_vid2;

    always @(posedge clk or negedge rst_n) begin : mdl
        automatic bit               pce = ((m_cyc % DIV) == DIV - 1);
        automatic logic [N_BTN-1:0] nl  = m_level;
        automatic int               L;
        automatic bit               all_diff;
        if (!rst_n) begin
            m_cyc   <= 0;
            m_level <= '0;
            m_rise  <= '0;
            m_vid1  <= {2'b11, 12'h000};
            m_vid2  <= {2'b11, 12'h000};
            m_hist.delete();
            for (int i = 0; i < DEB + 2; i++) m_hist.push_back('0);
        end else begin
            m_hist.push_back(btn_raw);
            L = m_hist.size();
            for (int b = 0; b < N_BTN; b++) begin
                all_diff = 1;
                for (int j = 0; j < DEB; j++)
                    if (m_hist[L-3-j][b] == m_level[b]) all_diff = 0;
                if (all_diff) nl[b] = ~m_level[b];
            end
            void'(m_hist.pop_front());
            m_rise  <= (m_rise & ~{N_BTN{pce}}) | (nl & ~m_level);
            m_level <= nl;
            m_cyc   <= m_cyc + 1;
            if (pce) begin
                m_vid1 <= {core_hs, core_vs, x1(core_r1), x1(core_g1), x1(core_b1)};
                m_vid2 <= {core_hs, core_vs, x2(core_r2), x2(core_g2), x2(core_b2)};
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_pix_ce",  {31'd0, pix_ce},  {31'd0, ((m_cyc % DIV) == DIV - 1)});
            check("mdl_pix_clk", {31'd0, pix_clk}, {31'd0, ((m_cyc % DIV) >= DIV / 2)});
            check("mdl_btn_level", 32'(btn_level), 32'(m_level));
            check("mdl_btn_rise",  32'(btn_rise),  32'(m_rise));
            check("mdl_video1", 32'({vga_hs1, vga_vs1, vga_r1, vga_g1, vga_b1}), 32'(m_vid1));
            check("mdl_video2", 32'({vga_hs2, vga_vs2, vga_r2, vga_g2, vga_b2}), 32'(m_vid2));
            check("mdl_dut2_ctl", 32'({pix_ce2, pix_clk2, btn_level2, btn_rise2}),
                  32'({pix_ce, pix_clk, m_level, m_rise}));
        end
    end

    task automatic wait_pce(input string name);
        bit ok = 0;
        for (int i = 0; i < 2 * DIV; i++) begin
            @(negedge clk);
            if (pix_ce) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: pix_ce not seen within %0d cycles", name, 2 * DIV);
        end
    endtask

    typedef struct {
        logic        r1, g1, b1, hs, vs;
        logic [1:0]  r2, g2, b2;
        logic [13:0] e1, e2;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 2'b11,
                   {1'b0, 1'b1, 4'hF, 4'h0, 4'hF}, {1'b0, 1'b1, 4'h0, 4'hA, 4'hF}};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b11, 2'b00,
                   {1'b1, 1'b0, 4'h0, 4'hF, 4'h0}, {1'b1, 1'b0, 4'h5, 4'hF, 4'h0}};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 2'b10,
                   {1'b1, 1'b1, 4'hF, 4'hF, 4'hF}, {1'b1, 1'b1, 4'hA, 4'h5, 4'hA}};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b01,
                   {1'b0, 1'b0, 4'h0, 4'h0, 4'h0}, {1'b0, 1'b0, 4'hF, 4'h0, 4'h5}};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_video1", 32'({vga_hs1, vga_vs1, vga_r1, vga_g1, vga_b1}), 32'h3000);
        check("rst_video2", 32'({vga_hs2, vga_vs2, vga_r2, vga_g2, vga_b2}), 32'h3000);
        check("rst_ctl", 32'({pix_ce, pix_clk, btn_level, btn_rise}), 32'h0);
        chk_en = 1;

        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("seq_pix_ce",  {31'd0, pix_ce},  {31'd0, (i % 4) == 3});
            check("seq_pix_clk", {31'd0, pix_clk}, {31'd0, (i % 4) >= 2});
        end

        // Video vectors: capture on the next pix_ce edge, then hold while inputs change.
        for (int t = 0; t < 4; t++) begin
            wait_pce("tbl_wait");
            {core_r1, core_g1, core_b1, core_hs, core_vs} =
                {tbl[t].r1, tbl[t].g1, tbl[t].b1, tbl[t].hs, tbl[t].vs};
            {core_r2, core_g2, core_b2} = {tbl[t].r2, tbl[t].g2, tbl[t].b2};
            @(negedge clk);
            check("tbl_video1", 32'({vga_hs1, vga_vs1, vga_r1, vga_g1, vga_b1}), 32'(tbl[t].e1));
            check("tbl_video2", 32'({vga_hs2, vga_vs2, vga_r2, vga_g2, vga_b2}), 32'(tbl[t].e2));
            {core_r1, core_g1, core_b1, core_hs, core_vs} =
                ~{tbl[t].r1, tbl[t].g1, tbl[t].b1, tbl[t].hs, tbl[t].vs};
            {core_r2, core_g2, core_b2} = ~{tbl[t].r2, tbl[t].g2, tbl[t].b2};
            @(negedge clk);
            check("tbl_hold1", 32'({vga_hs1, vga_vs1, vga_r1, vga_g1, vga_b1}), 32'(tbl[t].e1));
            check("tbl_hold2", 32'({vga_hs2, vga_vs2, vga_r2, vga_g2, vga_b2}), 32'(tbl[t].e2));
        end

        // Button 0 press: level appears DEB+1 edges after the sampling edge.
        btn_raw[0] = 1'b1;
        repeat (9) @(negedge clk);
        check("deb_early_level", {31'd0, btn_level[0]}, 32'd0);
        @(negedge clk);
        check("deb_level", {31'd0, btn_level[0]}, 32'd1);
        check("deb_rise",  {31'd0, btn_rise[0]},  32'd1);
        check("deb_other_level", 32'(btn_level[2:1]), 32'd0);
        check("deb_other_rise",  32'(btn_rise[2:1]),  32'd0);
        for (int i = 0; i < 2 * DIV; i++) begin
            check("stretch_hold", {31'd0, btn_rise[0]}, 32'd1);
            if (pix_ce) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("stretch_clear", {31'd0, btn_rise[0]}, 32'd0);

        // Release produces no pulse.
        btn_raw[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("release_no_rise", {31'd0, btn_rise[0]}, 32'd0);
        end
        check("release_level", {31'd0, btn_level[0]}, 32'd0);

        // Glitches one cycle shorter than the debounce window are rejected.
        for (int g = 0; g < 4; g++) begin
            btn_raw[1] = 1'b1;
            repeat (DEB - 1) @(negedge clk);
            btn_raw[1] = 1'b0;
            repeat (DEB + 1) @(negedge clk);
            check("glitch_level", {31'd0, btn_level[1]}, 32'd0);
            check("glitch_rise",  {31'd0, btn_rise[1]},  32'd0);
        end

        // Press timed so the level edge coincides with a pix_ce edge.
        wait_pce("coin_wait");
        repeat (DIV - 1) @(negedge clk);
        btn_raw[0] = 1'b1;
        repeat (10) @(negedge clk);
        check("coin_set", {30'd0, btn_rise[0], pix_ce}, 32'd2);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("coin_hold", {31'd0, btn_rise[0]}, 32'd1);
        end
        check("coin_next_pce", {31'd0, pix_ce}, 32'd1);
        @(negedge clk);
        check("coin_clear", {31'd0, btn_rise[0]}, 32'd0);

        // Asynchronous reset in mid-count (cnt == 2) with button 0 held high.
        for (int i = 0; i < 2 * DIV; i++) begin
            if (pix_clk && !pix_ce) break;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctl", 32'({pix_ce, pix_clk, btn_level, btn_rise}), 32'h0);
        check("arst_video1", 32'({vga_hs1, vga_vs1, vga_r1, vga_g1, vga_b1}), 32'h3000);
        @(negedge clk);
        btn_raw = '0;
        rst_n   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("arst_pix_ce", {31'd0, pix_ce}, {31'd0, (i % 4) == 3});
        end

        // Random traffic against the model.
        repeat (3000) begin
            @(negedge clk);
            for (int b = 0; b < N_BTN; b++)
                if ($urandom_range(0, 11) == 0) btn_raw[b] = ~btn_raw[b];
            {core_r1, core_g1, core_b1, core_hs, core_vs} = 5'($urandom);
            {core_r2, core_g2, core_b2} = 6'($urandom);
        end

        @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
